// File: rtl/cam_pkg.sv
// cam_pkg: shared types for the camera burst writer.
package cam_pkg;

  localparam int CAM_DATA_W = 16;

  // One RGB565 pixel as it leaves the capture stage.
  typedef logic [CAM_DATA_W-1:0] rgb565_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } wr_state_e;

  // Frame-drop counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cam_burst_writer_if.sv
// cam_burst_writer_if: burst request + write data bus toward the frame-buffer controller.
interface cam_burst_writer_if
  import cam_pkg::*;
#(
  parameter int DATA_W = CAM_DATA_W,
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 7
);
  logic              burst_req;
  logic [ADDR_W-1:0] burst_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              burst_ack;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  modport master (
    output burst_req, burst_addr, burst_len, wr_data, wr_valid,
    input  burst_ack, wr_ready
  );

  modport slave (
    input  burst_req, burst_addr, burst_len, wr_data, wr_valid,
    output burst_ack, wr_ready
  );
endinterface

// File: rtl/cam_sync_fifo.sv
// cam_sync_fifo: single-clock show-ahead FIFO; dout_o is always the oldest word.
// Pushes into a full FIFO and pops from an empty one are ignored.
module cam_sync_fifo
  import cam_pkg::*;
#(
  parameter int DATA_W = CAM_DATA_W,
  parameter int DEPTH  = 512
) (
  input  logic                     pclk_2x,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        din_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array; left unreset since the pointers define what is valid.
  always_ff @(posedge pclk_2x) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge pclk_2x) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cam_burst_writer.sv
// cam_burst_writer: buffers the captured pixel stream and emits fixed-length
// linear write bursts, alternating between two frame buffers. The tail of a
// frame goes out as one short burst once the frame has ended.
//
// state | meaning
// IDLE  | wait for a full burst in the FIFO, or the frame tail / frame end
// REQ   | burst_req held with stable address/length until burst_ack
// DATA  | stream burst_len words from the FIFO head, one per handshake
module cam_burst_writer
  import cam_pkg::*;
#(
  parameter int                DATA_W     = CAM_DATA_W,
  parameter int                ADDR_W     = 24,
  parameter int                BURST_LEN  = 64,
  parameter int                FIFO_DEPTH = 512,
  parameter logic [ADDR_W-1:0] BASE0      = 'h000000,
  parameter logic [ADDR_W-1:0] BASE1      = 'h080000
) (
  input  logic                pclk_2x,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   pre_data_i,
  input  logic                pre_de_i,
  input  logic                vs_o_i,
  cam_burst_writer_if.master  bus,
  output logic                buf_sel_o,
  output logic                frame_done_o,
  output logic                overflow_o,
  output logic [7:0]          drop_cnt_o
);
  localparam int LEN_W = $clog2(BURST_LEN) + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Input stage registers.
  logic [DATA_W-1:0] data_q;
  logic              de_q, vs_q, vs_dly_q;
  logic              vs_rise, vs_fall;

  // Frame bookkeeping.
  logic              cap_q, buf_q, ovf_q;
  logic [7:0]        drop_q;
  logic              frame_ok, accept, drop, push;

  // Burst FSM.
  wr_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              eof_q, eof_d;
  logic              done_q, done_d;
  logic              req, valid, pop;

  // FIFO side.
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  // Register the capture-stage outputs once; vs edges come from this copy.
  always_ff @(posedge pclk_2x) begin
    if (!rst_n) begin
      data_q   <= '0;
      de_q     <= 1'b0;
      vs_q     <= 1'b0;
      vs_dly_q <= 1'b0;
    end else begin
      data_q   <= pre_data_i;
      de_q     <= pre_de_i;
      vs_q     <= vs_o_i;
      vs_dly_q <= vs_q;
    end
  end

  assign vs_rise = vs_q && !vs_dly_q;
  assign vs_fall = !vs_q && vs_dly_q;

  // A new frame is only taken when the previous one has fully drained;
  // otherwise it is skipped whole so no buffer ever mixes two frames.
  assign frame_ok = (state_q == ST_IDLE) && fifo_empty && !eof_q;
  assign accept   = vs_rise && frame_ok;
  assign drop     = vs_rise && !frame_ok;
  // A pixel coinciding with the accepted vs edge is already part of the frame.
  assign push     = de_q && vs_q && (cap_q || accept);

  // Frame acceptance, buffer ping-pong, overflow flag and drop counter.
  always_ff @(posedge pclk_2x) begin
    if (!rst_n) begin
      cap_q  <= 1'b0;
      buf_q  <= 1'b1;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (accept) begin
        cap_q <= 1'b1;
        buf_q <= !buf_q;
        ovf_q <= 1'b0;
      end else if (drop) begin
        drop_q <= sat_inc8(drop_q);
      end
      if (vs_fall && cap_q) cap_q <= 1'b0;
      if (push && fifo_full) ovf_q <= 1'b1;
    end
  end

  cam_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .pclk_2x (pclk_2x),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (data_q),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM state and burst bookkeeping registers.
  always_ff @(posedge pclk_2x) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      rem_q   <= '0;
      addr_q  <= BASE0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      eof_q   <= eof_d;
      done_q  <= done_d;
    end
  end

  // Next-state and bus outputs; rem_q counts down the words left in a burst.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    eof_d   = eof_q;
    done_d  = 1'b0;
    req     = 1'b0;
    valid   = 1'b0;
    pop     = 1'b0;

    if (vs_fall && cap_q) eof_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) addr_d = buf_q ? BASE0 : BASE1;
        if (fifo_count >= CNT_W'(BURST_LEN)) begin
          len_d   = LEN_W'(BURST_LEN);
          state_d = ST_REQ;
        end else if (eof_q && (fifo_count != '0)) begin
          len_d   = LEN_W'(fifo_count);
          state_d = ST_REQ;
        end else if (eof_q) begin
          done_d = 1'b1;
          eof_d  = 1'b0;
        end
      end
      ST_REQ: begin
        req = 1'b1;
        if (bus.burst_ack) begin
          rem_d   = len_q;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        valid = 1'b1;
        pop   = bus.wr_ready;
        if (bus.wr_ready) begin
          if (rem_q == LEN_W'(1)) begin
            addr_d  = addr_q + ADDR_W'(len_q);
            state_d = ST_IDLE;
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.burst_req  = req;
  assign bus.burst_addr = addr_q;
  assign bus.burst_len  = len_q;
  assign bus.wr_valid   = valid;
  assign bus.wr_data    = valid ? fifo_dout : '0;

  assign buf_sel_o    = buf_q;
  assign frame_done_o = done_q;
  assign overflow_o   = ovf_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_cam_burst_writer.sv
// tb_cam_burst_writer: frame-level checks of the burst writer against an
// arithmetic model of the expected bursts and the recorded pixel stream.
module tb_cam_burst_writer;
  import cam_pkg::*;

  localparam logic [23:0] BASE0 = 24'h000000;
  localparam logic [23:0] BASE1 = 24'h080000;
  localparam int          BL    = 64;

  logic        pclk_2x = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] pre_data = '0;
  logic        pre_de   = 1'b0;
  logic        vs       = 1'b0;
  logic        buf_sel, frame_done, overflow;
  logic [7:0]  drop_cnt;

  cam_burst_writer_if #(.DATA_W(16), .ADDR_W(24), .LEN_W(7)) bus ();

  cam_burst_writer #(
    .DATA_W(16), .ADDR_W(24), .BURST_LEN(64), .FIFO_DEPTH(512),
    .BASE0(24'h000000), .BASE1(24'h080000)
  ) dut (
    .pclk_2x      (pclk_2x),
    .rst_n        (rst_n),
    .pre_data_i   (pre_data),
    .pre_de_i     (pre_de),
    .vs_o_i       (vs),
    .bus          (bus),
    .buf_sel_o    (buf_sel),
    .frame_done_o (frame_done),
    .overflow_o   (overflow),
    .drop_cnt_o   (drop_cnt)
  );

  always #5 pclk_2x = ~pclk_2x;

  typedef struct {
    logic [23:0] addr;
    int          len;
  } burst_t;

  typedef struct {
    int          npix;
    int          de_pct;
    int          rmode;
    logic        bufx;
    logic [23:0] addr0;
    int          nb;
    int          last_len;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int prot_err = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  logic mon_clear = 1'b0;
  int req_age = 0;

  burst_t      got_b[$];
  logic [15:0] got_w[$];
  logic [15:0] exp_w[$];

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pclk_2x);
    #1;
  endtask

  // Memory-controller model: acks two cycles after a request, ready per mode.
  initial begin
    bus.burst_ack = 1'b0;
    bus.wr_ready  = 1'b0;
    forever begin
      @(posedge pclk_2x);
      #1;
      bus.burst_ack = 1'b0;
      if (bus.burst_req) begin
        req_age++;
        if (req_age == 2) bus.burst_ack = 1'b1;
      end else begin
        req_age = 0;
      end
      case (ready_mode)
        0:       bus.wr_ready = 1'b1;
        1:       bus.wr_ready = ($urandom_range(3) != 0);
        default: bus.wr_ready = 1'b0;
      endcase
    end
  end

  // Bus monitor: records bursts and words, flags protocol violations.
  initial begin
    burst_t b;
    int words_left;
    logic prev_req_wait, prev_stall;
    logic [23:0] prev_addr;
    logic [6:0]  prev_len;
    logic [15:0] prev_data;
    words_left = 0; prev_req_wait = 0; prev_stall = 0;
    prev_addr = '0; prev_len = '0; prev_data = '0;
    forever begin
      @(negedge pclk_2x);
      if (mon_clear || !rst_n) begin
        got_b.delete();
        got_w.delete();
        words_left = 0;
        prev_req_wait = 0;
        prev_stall = 0;
      end else begin
        if (prev_req_wait && !(bus.burst_req && bus.burst_addr == prev_addr && bus.burst_len == prev_len))
          prot_err++;
        if (prev_stall && !(bus.wr_valid && bus.wr_data == prev_data)) prot_err++;
        if (bus.burst_req && bus.burst_ack) begin
          b.addr = bus.burst_addr;
          b.len  = int'(bus.burst_len);
          got_b.push_back(b);
          words_left = b.len;
        end else if (bus.wr_valid && words_left == 0) begin
          prot_err++;
        end
        if (bus.wr_valid && bus.wr_ready) begin
          if (words_left > 0) words_left--;
          got_w.push_back(bus.wr_data);
        end
        if (frame_done) done_cnt++;
        prev_req_wait = bus.burst_req && !bus.burst_ack;
        prev_addr     = bus.burst_addr;
        prev_len      = bus.burst_len;
        prev_stall    = bus.wr_valid && !bus.wr_ready;
        prev_data     = bus.wr_data;
      end
    end
  end

  task automatic clear_monitor();
    mon_clear = 1'b1;
    @(negedge pclk_2x);
    #1;
    mon_clear = 1'b0;
    cyc();
  endtask

  // One frame: vs high, npix pixels with random de gaps, vs low, then some
  // de activity with vs low that must be ignored.
  task automatic send_frame(input int npix, input int de_pct, input bit keep);
    vs = 1'b1;
    pre_de = 1'b0;
    repeat (3) cyc();
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(99) >= de_pct) begin
        pre_de = 1'b0;
        pre_data = 16'($urandom);
        cyc();
      end
      pre_de = 1'b1;
      pre_data = 16'($urandom);
      if (keep) exp_w.push_back(pre_data);
      cyc();
    end
    pre_de = 1'b0;
    repeat (3) cyc();
    vs = 1'b0;
    repeat (2) cyc();
    pre_de = 1'b1;
    pre_data = 16'hDEAD;
    repeat (3) cyc();
    pre_de = 1'b0;
    cyc();
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      cyc();
      n++;
    end
    check({name, " frame_done_seen"}, longint'(done_cnt != d0), 1);
    repeat (4) cyc();
  endtask

  task automatic check_reset(input string name);
    check({name, " burst_req"},  bus.burst_req, 0);
    check({name, " burst_addr"}, bus.burst_addr, BASE0);
    check({name, " burst_len"},  bus.burst_len, 0);
    check({name, " wr_valid"},   bus.wr_valid, 0);
    check({name, " wr_data"},    bus.wr_data, 0);
    check({name, " buf_sel"},    buf_sel, 1);
    check({name, " frame_done"}, frame_done, 0);
    check({name, " overflow"},   overflow, 0);
    check({name, " drop_cnt"},   drop_cnt, 0);
  endtask

  // Expected bursts follow from the pixel count alone: full bursts from the
  // buffer base upward, then one short tail burst.
  task automatic check_frame(input string name, input int nb, input int last_len,
                             input logic [23:0] addr0, input logic bufx,
                             input int d0, input logic exp_ovf);
    int n, errs, el, nw;
    logic [23:0] ea;
    n = exp_w.size();
    check({name, " nbursts"}, got_b.size(), nb);
    if (nb > 0) begin
      check({name, " first_addr"}, (got_b.size() > 0) ? longint'(got_b[0].addr) : -1, addr0);
      check({name, " last_len"}, (got_b.size() > 0) ? longint'(got_b[got_b.size()-1].len) : -1, last_len);
    end
    errs = 0;
    for (int k = 0; k < got_b.size(); k++) begin
      ea = addr0 + 24'(BL * k);
      el = ((n - BL * k) > BL) ? BL : (n - BL * k);
      if (got_b[k].addr !== ea) errs++;
      if (got_b[k].len != el) errs++;
    end
    check({name, " burst_shape_errs"}, errs, 0);
    check({name, " nwords"}, got_w.size(), n);
    nw = (got_w.size() < n) ? got_w.size() : n;
    errs = 0;
    for (int i = 0; i < nw; i++) if (got_w[i] !== exp_w[i]) errs++;
    check({name, " data_errs"}, errs, 0);
    check({name, " buf_sel"}, buf_sel, bufx);
    check({name, " frame_done_count"}, done_cnt - d0, 1);
    check({name, " overflow"}, overflow, exp_ovf);
    check({name, " protocol_errs"}, prot_err, 0);
    exp_w.delete();
    clear_monitor();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=time_limit_reached expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t tbl[8];
    int d0, n;
    tbl[0] = '{npix: 100,  de_pct: 100, rmode: 0, bufx: 1'b0, addr0: BASE0, nb: 2,  last_len: 36};
    tbl[1] = '{npix: 128,  de_pct: 70,  rmode: 1, bufx: 1'b1, addr0: BASE1, nb: 2,  last_len: 64};
    tbl[2] = '{npix: 1,    de_pct: 100, rmode: 1, bufx: 1'b0, addr0: BASE0, nb: 1,  last_len: 1};
    tbl[3] = '{npix: 0,    de_pct: 100, rmode: 0, bufx: 1'b1, addr0: BASE1, nb: 0,  last_len: 0};
    tbl[4] = '{npix: 64,   de_pct: 50,  rmode: 1, bufx: 1'b0, addr0: BASE0, nb: 1,  last_len: 64};
    tbl[5] = '{npix: 200,  de_pct: 80,  rmode: 1, bufx: 1'b1, addr0: BASE1, nb: 4,  last_len: 8};
    tbl[6] = '{npix: 3000, de_pct: 100, rmode: 0, bufx: 1'b0, addr0: BASE0, nb: 47, last_len: 56};
    tbl[7] = '{npix: 700,  de_pct: 60,  rmode: 1, bufx: 1'b1, addr0: BASE1, nb: 11, last_len: 60};

    rst_n = 1'b0;
    ready_mode = 0;
    repeat (4) cyc();
    rst_n = 1'b1;
    cyc();
    check_reset("reset");

    for (int i = 0; i < 8; i++) begin
      ready_mode = tbl[i].rmode;
      d0 = done_cnt;
      send_frame(tbl[i].npix, tbl[i].de_pct, 1'b1);
      wait_done(d0, 20000, $sformatf("vec%0d", i));
      check_frame($sformatf("vec%0d", i), tbl[i].nb, tbl[i].last_len,
                  tbl[i].addr0, tbl[i].bufx, d0, 1'b0);
    end

    // Controller stalls: 512 pixels fit, the rest of the line is lost.
    ready_mode = 2;
    d0 = done_cnt;
    send_frame(640, 100, 1'b1);
    repeat (400) cyc();
    check("ovf sticky_while_stalled", overflow, 1);
    check("ovf no_frame_done_while_stalled", done_cnt - d0, 0);
    ready_mode = 0;
    wait_done(d0, 5000, "ovf");
    while (exp_w.size() > 512) void'(exp_w.pop_back());
    check_frame("ovf", 8, 64, BASE0, 1'b0, d0, 1'b1);

    // A frame starting while the previous one still drains is dropped.
    ready_mode = 2;
    d0 = done_cnt;
    send_frame(300, 100, 1'b1);
    check("dropA overflow_cleared", overflow, 0);
    send_frame(50, 100, 1'b0);
    check("drop drop_cnt", drop_cnt, 1);
    ready_mode = 0;
    wait_done(d0, 5000, "dropA");
    check_frame("dropA", 5, 44, BASE1, 1'b1, d0, 1'b0);
    d0 = done_cnt;
    send_frame(100, 100, 1'b1);
    wait_done(d0, 5000, "dropC");
    check_frame("dropC", 2, 36, BASE0, 1'b0, d0, 1'b0);
    check("dropC drop_cnt_hold", drop_cnt, 1);

    // Reset pulse in the middle of a data burst.
    ready_mode = 0;
    vs = 1'b1;
    pre_de = 1'b0;
    repeat (2) cyc();
    n = 0;
    while (n < 2000 && !(bus.wr_valid && got_w.size() >= 10)) begin
      pre_de = 1'b1;
      pre_data = 16'($urandom);
      cyc();
      n++;
    end
    check("midrst reached_data", bus.wr_valid, 1);
    rst_n = 1'b0;
    vs = 1'b0;
    pre_de = 1'b0;
    cyc();
    check_reset("midrst");
    check("midrst fifo_count", dut.fifo_count, 0);
    rst_n = 1'b1;
    exp_w.delete();
    repeat (2) cyc();
    clear_monitor();
    d0 = done_cnt;
    send_frame(640, 100, 1'b1);
    wait_done(d0, 5000, "postrst");
    check_frame("postrst", 10, 64, BASE0, 1'b0, d0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
